// File: rtl/line_scaler_buffer_pkg.sv
// Shared display-path definitions: pixel packing, NES active width and VGA line totals.
// Used by the line buffer and by the timing / TMDS blocks downstream.
package line_scaler_buffer_pkg;

    localparam int PIX_W_DEF    = 24;
    localparam int NES_ACTIVE_W = 256;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_TOTAL  = 800;

    // {blue,green,red} packing, red in the LSBs
    localparam int CHAN_W  = 8;
    localparam int RED_LSB = 0;
    localparam int GRN_LSB = 8;
    localparam int BLU_LSB = 16;

    function automatic logic [PIX_W_DEF-1:0] pack_rgb(
        input logic [CHAN_W-1:0] r,
        input logic [CHAN_W-1:0] g,
        input logic [CHAN_W-1:0] b
    );
        return {b, g, r};
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Simple dual-port line storage: one write port, one registered read port.
// Latency: 1 cycle read. No backpressure; caller owns address arbitration.
module line_bank_ram #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    (* ram_style = "BLOCK" *) logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/line_scaler_buffer.sv
// Ping-pong line buffer: captures source lines, replays them HSCALE x wide and VREP x tall.
// Latency: out_valid/out_data follow out_req by 2 cycles.
// No backpressure: lines arriving while both banks are owned are dropped and flagged.
module line_scaler_buffer
    import line_scaler_buffer_pkg::*;
#(
    parameter int               PIX_W     = PIX_W_DEF,
    parameter int               IN_WIDTH  = NES_ACTIVE_W,
    parameter int               ADDR_W    = 8,
    parameter int               HSCALE    = 2,
    parameter int               VREP      = 2,
    parameter logic [PIX_W-1:0] BLANK_VAL = '0
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sol,
    input  logic [PIX_W-1:0] in_data,
    input  logic             out_line_start,
    input  logic             out_req,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             line_avail,
    output logic             ovf_sticky,
    output logic             udf_sticky,
    input  logic             status_clr
);

    localparam int XW = ADDR_W + 1;
    localparam int HW = (HSCALE > 1) ? $clog2(HSCALE) : 1;
    localparam int RW = (VREP > 1) ? $clog2(VREP) : 1;

    localparam logic [XW-1:0] X_END  = XW'(IN_WIDTH);
    localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HSCALE - 1);
    localparam logic [RW-1:0] R_LAST = RW'(VREP - 1);

    logic          wr_bank;
    logic [XW-1:0] wr_x;
    logic [1:0]    full;
    logic          drop;
    logic          rd_bank;
    logic [XW-1:0] rd_x;
    logic [HW-1:0] h_sub;
    logic [RW-1:0] rep_cnt;
    logic          cur_valid;
    logic          req_d1;
    logic          blank_d1;

    logic             wr_en;
    logic [XW-1:0]    wr_addr_x;
    logic             wr_done;
    logic             ovf_evt;
    logic             rel;
    logic             nxt_rd_bank;
    logic             udf_evt;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;
    logic [1:0]       full_nxt;
    logic [PIX_W-1:0] rd_data;

    always_comb begin
        wr_addr_x = in_sol ? '0 : wr_x;
        wr_en     = 1'b0;
        if (in_valid)
            wr_en = in_sol ? !full[wr_bank] : (!drop && (wr_x < X_END));
        wr_done = wr_en && (wr_addr_x == X_LAST);
        ovf_evt = in_valid && in_sol && full[wr_bank];

        // Bank hand-back happens only once the current line has been shown VREP times
        rel         = out_line_start && cur_valid && (rep_cnt == R_LAST);
        nxt_rd_bank = rd_bank ^ rel;
        udf_evt     = out_line_start && !full[nxt_rd_bank];

        full_set = '0;
        full_clr = '0;
        if (wr_done)
            full_set[wr_bank] = 1'b1;
        if (rel)
            full_clr[rd_bank] = 1'b1;
        full_nxt = (full & ~full_clr) | full_set;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            wr_x       <= '0;
            full       <= '0;
            drop       <= 1'b1;
            rd_bank    <= 1'b0;
            rd_x       <= '0;
            h_sub      <= '0;
            rep_cnt    <= '0;
            cur_valid  <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
            req_d1     <= 1'b0;
            blank_d1   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= BLANK_VAL;
            line_avail <= 1'b0;
        end else begin
            if (in_valid) begin
                if (in_sol) begin
                    drop <= full[wr_bank];
                    wr_x <= XW'(1);
                end else if (wr_x < X_END) begin
                    wr_x <= wr_x + 1'b1;
                end
                if (wr_done)
                    wr_bank <= ~wr_bank;
            end

            full       <= full_nxt;
            line_avail <= |full_nxt;

            if (out_line_start) begin
                rd_bank   <= nxt_rd_bank;
                cur_valid <= full[nxt_rd_bank];
                if (udf_evt || rel)
                    rep_cnt <= '0;
                else if (cur_valid)
                    rep_cnt <= rep_cnt + 1'b1;
                rd_x  <= '0;
                h_sub <= '0;
            end else if (out_req) begin
                if (h_sub == H_LAST) begin
                    h_sub <= '0;
                    if (rd_x < X_END)
                        rd_x <= rd_x + 1'b1;
                end else begin
                    h_sub <= h_sub + 1'b1;
                end
            end

            ovf_sticky <= (ovf_sticky && !status_clr) || ovf_evt;
            udf_sticky <= (udf_sticky && !status_clr) || udf_evt;

            // Blank decision travels alongside the RAM read so both land together
            req_d1    <= out_req;
            blank_d1  <= (rd_x >= X_END) || !cur_valid;
            out_valid <= req_d1;
            out_data  <= (req_d1 && !blank_d1) ? rd_data : BLANK_VAL;
        end
    end

    line_bank_ram #(
        .DATA_W (PIX_W),
        .ADDR_W (XW)
    ) u_ram (
        .clk     (pclk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_addr_x[ADDR_W-1:0]}),
        .wr_data (in_data),
        .rd_en   (out_req),
        .rd_addr ({rd_bank, rd_x[ADDR_W-1:0]}),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_line_scaler_buffer.sv
// Directed bench for line_scaler_buffer: default 2x2 instance plus a 1x3 / 320-wide instance.
module tb_line_scaler_buffer;

    localparam logic [23:0] BLANK = 24'hDEAD00;

    logic        pclk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sol;
    logic [23:0] in_data;
    logic        out_line_start;
    logic        out_req;
    logic        status_clr;

    logic        out_valid_a, line_avail_a, ovf_a, udf_a;
    logic [23:0] out_data_a;
    logic        out_valid_b, line_avail_b, ovf_b, udf_b;
    logic [23:0] out_data_b;

    int n_chk  = 0;
    int n_fail = 0;
    logic [23:0] cap_a[$];
    logic [23:0] cap_b[$];

    line_scaler_buffer #(
        .PIX_W(24), .IN_WIDTH(256), .ADDR_W(8), .HSCALE(2), .VREP(2), .BLANK_VAL(BLANK)
    ) u_a (
        .pclk(pclk), .rst(rst), .in_valid(in_valid), .in_sol(in_sol), .in_data(in_data),
        .out_line_start(out_line_start), .out_req(out_req), .out_valid(out_valid_a),
        .out_data(out_data_a), .line_avail(line_avail_a), .ovf_sticky(ovf_a),
        .udf_sticky(udf_a), .status_clr(status_clr)
    );

    line_scaler_buffer #(
        .PIX_W(24), .IN_WIDTH(320), .ADDR_W(9), .HSCALE(1), .VREP(3), .BLANK_VAL(BLANK)
    ) u_b (
        .pclk(pclk), .rst(rst), .in_valid(in_valid), .in_sol(in_sol), .in_data(in_data),
        .out_line_start(out_line_start), .out_req(out_req), .out_valid(out_valid_b),
        .out_data(out_data_b), .line_avail(line_avail_b), .ovf_sticky(ovf_b),
        .udf_sticky(udf_b), .status_clr(status_clr)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (out_valid_a) cap_a.push_back(out_data_a);
        if (out_valid_b) cap_b.push_back(out_data_b);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic send_line(input int n, input bit ramp, input logic [23:0] val);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sol   = (i == 0);
            in_data  = ramp ? 24'(i) + val : val;
            tick(1);
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
        tick(2);
    endtask

    task automatic line_start();
        out_line_start = 1'b1;
        tick(1);
        out_line_start = 1'b0;
        tick(1);
    endtask

    task automatic request(input int n);
        cap_a.delete();
        cap_b.delete();
        out_req = 1'b1;
        tick(n);
        out_req = 1'b0;
        tick(4);
    endtask

    // Expected replay: each source pixel shown hs times, blank past the stored width
    function automatic logic [23:0] exp_pix(input int k, input int hs, input int w,
                                            input bit ramp, input logic [23:0] val);
        if (k / hs >= w) return BLANK;
        return ramp ? 24'(k / hs) + val : val;
    endfunction

    task automatic check_cap(input string tag, input bit sel, input int n, input int hs,
                             input int w, input bit ramp, input logic [23:0] val);
        int          bad;
        int          first;
        int          size;
        logic [23:0] d;
        bad   = 0;
        first = -1;
        size  = sel ? cap_b.size() : cap_a.size();
        chk({tag, "_len"}, size, n);
        for (int k = 0; k < size && k < n; k++) begin
            d = sel ? cap_b[k] : cap_a[k];
            if (d !== exp_pix(k, hs, w, ramp, val)) begin
                if (first < 0) first = k;
                bad++;
            end
        end
        if (bad != 0)
            $display("  %s first bad beat %0d", tag, first);
        chk({tag, "_bad"}, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sol = 1'b0; in_data = '0;
        out_line_start = 1'b0; out_req = 1'b0; status_clr = 1'b0;
        tick(3);
        chk("rst_valid", out_valid_a, 0);
        chk("rst_data", out_data_a, BLANK);
        chk("rst_avail", line_avail_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_udf", udf_a, 0);
        rst = 1'b0;
        tick(2);

        // Reset mid-stream while a line is being displayed and the next is being written
        send_line(256, 1'b0, 24'h55);
        chk("t1_avail_pre", line_avail_a, 1);
        line_start();
        out_req = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            in_valid = 1'b1;
            in_sol   = (i == 0);
            in_data  = 24'(i);
            if (i < 100) tick(1);
        end
        #2 rst = 1'b1;
        #1;
        chk("t1_valid", out_valid_a, 0);
        chk("t1_data", out_data_a, BLANK);
        chk("t1_avail", line_avail_a, 0);
        chk("t1_full", u_a.full, 2'b00);
        out_req  = 1'b0;
        in_valid = 1'b0;
        in_sol   = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        in_valid = 1'b1; in_data = 24'h99;
        tick(5);
        in_valid = 1'b0;
        tick(1);
        chk("t1_nosol_full", u_a.full, 2'b00);
        send_line(256, 1'b1, 24'h0);
        chk("t1_bank0", u_a.full, 2'b01);
        chk("t1_avail_post", line_avail_a, 1);

        // Basic 2x2 replay of the ramp captured above
        line_start();
        request(512);
        check_cap("t2_l0", 1'b0, 512, 2, 256, 1'b1, 24'h0);
        line_start();
        request(512);
        check_cap("t2_l1", 1'b0, 512, 2, 256, 1'b1, 24'h0);
        chk("t2_full_held", u_a.full, 2'b01);
        line_start();
        tick(1);
        chk("t2_full_rel", u_a.full, 2'b00);
        chk("t2_avail", line_avail_a, 0);
        chk("t2_udf", udf_a, 1);

        // Underrun
        do_reset();
        line_start();
        request(10);
        check_cap("t3", 1'b0, 10, 1, 0, 1'b0, BLANK);
        chk("t3_udf", udf_a, 1);
        chk("t3_idle_data", out_data_a, BLANK);
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        chk("t3_udf_clr", udf_a, 0);
        chk("t3_ovf", ovf_a, 0);

        // Overflow: third line dropped, display shows A A B B
        do_reset();
        send_line(256, 1'b0, 24'h00000A);
        send_line(256, 1'b0, 24'h00000B);
        chk("t4_ovf_pre", ovf_a, 0);
        send_line(256, 1'b0, 24'h00000C);
        chk("t4_ovf", ovf_a, 1);
        chk("t4_full", u_a.full, 2'b11);
        line_start(); request(512); check_cap("t4_l0", 1'b0, 512, 2, 256, 1'b0, 24'h00000A);
        line_start(); request(512); check_cap("t4_l1", 1'b0, 512, 2, 256, 1'b0, 24'h00000A);
        line_start(); request(512); check_cap("t4_l2", 1'b0, 512, 2, 256, 1'b0, 24'h00000B);
        line_start(); request(512); check_cap("t4_l3", 1'b0, 512, 2, 256, 1'b0, 24'h00000B);

        // Short line then full line of 7; over-width requests go blank
        do_reset();
        send_line(50, 1'b1, 24'h0);
        send_line(256, 1'b0, 24'h000007);
        line_start();
        request(600);
        check_cap("t5", 1'b0, 600, 2, 256, 1'b0, 24'h000007);
        chk("t5_ovf", ovf_a, 0);
        chk("t5_udf", udf_a, 0);

        // 1x3 instance, 320 wide: three replays, release on the 4th line start
        do_reset();
        send_line(320, 1'b1, 24'h0);
        send_line(320, 1'b1, 24'd1000);
        for (int r = 0; r < 3; r++) begin
            line_start();
            request(320);
            check_cap($sformatf("t6_rep%0d", r), 1'b1, 320, 1, 320, 1'b1, 24'h0);
        end
        chk("t6_full_held", u_b.full, 2'b11);
        line_start();
        chk("t6_full_rel", u_b.full, 2'b10);
        request(320);
        check_cap("t6_next", 1'b1, 320, 1, 320, 1'b1, 24'd1000);
        chk("t6_ovf", ovf_b, 0);
        chk("t6_udf", udf_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
